// File: rtl/tmds_out_pkg.sv
// Shared constants and types for the TMDS output path: mux select codes,
// blanking-encoder control words and the registered timing-output bundle.
package tmds_out_pkg;

  typedef enum logic [1:0] {
    SEL_BLANK = 2'b00,
    SEL_GUARD = 2'b01,
    SEL_VIDEO = 2'b10
  } sel_e;

  localparam logic [3:0] CTL_IDLE           = 4'b0000;
  localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;

  typedef struct packed {
    sel_e       sel;
    logic [3:0] ctl;
    logic       hsync;
    logic       vsync;
    logic       pix_req;
    logic       line_start;
    logic       frame_start;
  } tmg_out_t;

  localparam tmg_out_t OUT_IDLE = '{sel: SEL_BLANK, ctl: CTL_IDLE, default: 1'b0};

endpackage

// File: rtl/output_timing_ctrl_if.sv
// Timing bundle between the raster sequencer (master) and the output mux,
// encoders and pixel fetch (slave). The run enable travels with it.
interface output_timing_ctrl_if;
  import tmds_out_pkg::*;

  logic       en;
  sel_e       sel;
  logic [3:0] ctl;
  logic       hsync;
  logic       vsync;
  logic       pix_req;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  en,
    output sel, ctl, hsync, vsync, pix_req, line_start, frame_start
  );

  modport slave (
    output en,
    input  sel, ctl, hsync, vsync, pix_req, line_start, frame_start
  );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the increment
// that takes count from MAX back to zero.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = inc && (count == W'(MAX));

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc)
      count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/output_timing_ctrl.sv
// Raster timing sequencer: h/v position counters decoded into mux select,
// control preamble, syncs and a pixel request one cycle ahead of video.
module output_timing_ctrl
  import tmds_out_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output_timing_ctrl_if.master bus
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_PRE_LO = HW'(H_BLANK - GUARD_LEN - PREAMBLE_LEN);
  localparam logic [HW-1:0] H_GRD_LO = HW'(H_BLANK - GUARD_LEN);
  localparam logic [HW-1:0] H_VID_LO = HW'(H_BLANK);
  localparam logic [HW-1:0] H_REQ_LO = HW'(H_BLANK - 1);
  localparam logic [HW-1:0] H_REQ_HI = HW'(H_TOTAL - 2);
  localparam logic [HW-1:0] H_HS_LO  = HW'(H_FRONT);
  localparam logic [HW-1:0] H_HS_HI  = HW'(H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_LO  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_VS_HI  = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic          run;
  logic          clr;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  tmg_out_t      dec;
  tmg_out_t      out_q;

  // The first enabled cycle only arms run; counting starts one edge later so
  // that (0,0) appears on the outputs two edges after en is first sampled.
  assign clr = ~bus.en | ~run;

  wrap_counter #(.MAX(H_TOTAL - 1), .W(HW)) u_h (
    .clk(clk), .rst(rst), .clr(clr), .inc(1'b1), .count(h), .wrap(h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1), .W(VW)) u_v (
    .clk(clk), .rst(rst), .clr(clr), .inc(h_wrap), .count(v), .wrap(v_wrap)
  );

  // The frame can only roll over on the last pixel of a line.
  a_vwrap_on_hwrap: assert property (@(posedge clk) v_wrap |-> h_wrap);

  always_ff @(posedge clk) begin
    if (rst)
      run <= 1'b0;
    else
      run <= bus.en;
  end

  assign active = (v < V_ACT);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec = OUT_IDLE;
    if (active) begin
      if (h >= H_VID_LO)
        dec.sel = SEL_VIDEO;
      else if (h >= H_GRD_LO)
        dec.sel = SEL_GUARD;
      else if (h >= H_PRE_LO)
        dec.ctl = CTL_VIDEO_PREAMBLE;
    end
    dec.hsync       = (h >= H_HS_LO) && (h < H_HS_HI);
    dec.vsync       = (v >= V_VS_LO) && (v < V_VS_HI);
    dec.pix_req     = active && (h >= H_REQ_LO) && (h <= H_REQ_HI);
    dec.line_start  = (h == '0);
    dec.frame_start = (h == '0) && (v == '0);
  end

  // NOTE: the output register is reset because downstream mux/encoders act on it directly.
  always_ff @(posedge clk) begin
    if (rst || !bus.en || !run)
      out_q <= OUT_IDLE;
    else
      out_q <= dec;
  end

  assign bus.sel         = out_q.sel;
  assign bus.ctl         = out_q.ctl;
  assign bus.hsync       = out_q.hsync;
  assign bus.vsync       = out_q.vsync;
  assign bus.pix_req     = out_q.pix_req;
  assign bus.line_start  = out_q.line_start;
  assign bus.frame_start = out_q.frame_start;

endmodule

// File: tb/tb_output_timing_ctrl.sv
// Scoreboarded bench for output_timing_ctrl on a reduced raster so whole
// frames fit in a short run; directed stats cover line/frame boundaries.
module tb_output_timing_ctrl;
  import tmds_out_pkg::*;

  localparam int H_ACTIVE = 16, H_FRONT = 4, H_SYNC = 6, H_BACK = 12;
  localparam int V_ACTIVE = 6, V_FRONT = 2, V_SYNC = 2, V_BACK = 3;
  localparam int PRE = 8, GRD = 2;
  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_timing_ctrl_if bus ();
  initial bus.en = 1'b0;

  output_timing_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .PREAMBLE_LEN(PRE), .GUARD_LEN(GRD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for position (h,v), packed {sel,ctl,hs,vs,pr,ls,fs}.
  function automatic logic [10:0] model_out(input int h, input int v);
    logic [1:0] s;
    logic [3:0] c;
    bit act, hs, vs, pr;
    act = (v < V_ACTIVE);
    s   = 2'b00;
    c   = 4'b0000;
    if (act && h >= H_BLANK)            s = 2'b10;
    else if (act && h >= H_BLANK - GRD) s = 2'b01;
    if (act && h >= H_BLANK - GRD - PRE && h < H_BLANK - GRD) c = 4'b0001;
    hs = (h >= H_FRONT) && (h < H_FRONT + H_SYNC);
    vs = (v >= V_ACTIVE + V_FRONT) && (v < V_ACTIVE + V_FRONT + V_SYNC);
    pr = act && (h >= H_BLANK - 1) && (h <= H_TOTAL - 2);
    return {s, c, hs, vs, pr, (h == 0), (h == 0 && v == 0)};
  endfunction

  logic [10:0] sb[$];
  bit m_run = 0;
  int m_h = 0, m_v = 0;

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst    = r;
    bus.en = e;
    if (r || !e) begin
      sb.push_back(11'd0);
      m_run = 0; m_h = 0; m_v = 0;
    end else if (!m_run) begin
      sb.push_back(11'd0);
      m_run = 1;
    end else begin
      sb.push_back(model_out(m_h, m_v));
      m_h++;
      if (m_h == H_TOTAL) begin
        m_h = 0;
        m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
      end
    end
  endtask

  // Monitor state: scoreboard pop plus boundary statistics.
  int cyc = 0, last_ls = -1, last_fs = -1, ls_gap = -1, fs_gap = -1;
  int cur_line = 0, h_idx = 0, frame_no = 0, pr_cnt = 0, lines_chk = 0, pr_bad = 0;
  int pr_seen = 0, pr_follow_bad = 0, sel11 = 0, vblank_bad = 0;
  int hs_first = -1, hs_last = -1, pre_first = -1, pre_last = -1;
  int grd_first = -1, grd_last = -1, vid_first = -1, vs_first = -1, vs_last = -1;
  int fs_cyc = 0, vid_lat = -1;
  bit line_valid = 0, prev_pr = 0, vid_armed = 0;
  logic [10:0] obs, expv;

  always @(posedge clk) begin
    #1;
    cyc++;
    obs = {bus.sel, bus.ctl, bus.hsync, bus.vsync, bus.pix_req, bus.line_start, bus.frame_start};
    if (sb.size() > 0) begin
      expv = sb.pop_front();
      check("outputs", {21'd0, obs}, {21'd0, expv});
    end
    if (bus.sel == 2'b11) sel11++;
    if (prev_pr && bus.sel != SEL_VIDEO) pr_follow_bad++;
    prev_pr = bus.pix_req;
    if (bus.pix_req) pr_seen++;
    if (rst || !bus.en) line_valid = 0;
    if (bus.line_start) begin
      if (line_valid && cur_line < V_ACTIVE) begin
        lines_chk++;
        if (pr_cnt != H_ACTIVE) pr_bad++;
      end
      if (last_ls >= 0) ls_gap = cyc - last_ls;
      last_ls = cyc;
      if (bus.frame_start) begin
        if (last_fs >= 0) fs_gap = cyc - last_fs;
        last_fs    = cyc;
        frame_no++;
        cur_line   = 0;
        line_valid = 1;
        fs_cyc     = cyc;
        vid_armed  = 1;
      end else begin
        cur_line++;
      end
      h_idx  = 0;
      pr_cnt = 0;
    end else begin
      h_idx++;
    end
    if (bus.pix_req) pr_cnt++;
    if (vid_armed && bus.sel == SEL_VIDEO) begin
      vid_lat   = cyc - fs_cyc;
      vid_armed = 0;
    end
    if (line_valid && cur_line >= V_ACTIVE && (bus.sel != SEL_BLANK || bus.ctl != 4'd0 || bus.pix_req))
      vblank_bad++;
    if (line_valid && frame_no == 1) begin
      if (bus.vsync) begin
        if (vs_first < 0) vs_first = cur_line;
        vs_last = cur_line;
      end
      if (cur_line == 0) begin
        if (bus.hsync) begin if (hs_first < 0) hs_first = h_idx; hs_last = h_idx; end
        if (bus.ctl == 4'b0001) begin if (pre_first < 0) pre_first = h_idx; pre_last = h_idx; end
        if (bus.sel == SEL_GUARD) begin if (grd_first < 0) grd_first = h_idx; grd_last = h_idx; end
        if (bus.sel == SEL_VIDEO && vid_first < 0) vid_first = h_idx;
      end
    end
  end

  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset, then idle with en low.
    repeat (3) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    drain();
    check("idle_after_reset", {21'd0, bus.sel, bus.ctl, bus.hsync, bus.vsync, bus.pix_req,
                               bus.line_start, bus.frame_start}, 32'd0);

    // Two full frames from the origin.
    repeat (2 * FRAME + 3) step(1'b0, 1'b1);
    drain();
    check("line_period", ls_gap, H_TOTAL);
    check("frame_period", fs_gap, FRAME);
    check("active_lines_seen", lines_chk, 2 * V_ACTIVE);
    check("pix_req_per_line_bad", pr_bad, 0);
    check("pix_req_total", pr_seen, 2 * V_ACTIVE * H_ACTIVE);
    check("pix_req_then_video", pr_follow_bad, 0);
    check("hsync_first_h", hs_first, H_FRONT);
    check("hsync_last_h", hs_last, H_FRONT + H_SYNC - 1);
    check("preamble_first_h", pre_first, H_BLANK - GRD - PRE);
    check("preamble_last_h", pre_last, H_BLANK - GRD - 1);
    check("guard_first_h", grd_first, H_BLANK - GRD);
    check("guard_last_h", grd_last, H_BLANK - 1);
    check("video_first_h", vid_first, H_BLANK);
    check("vsync_first_line", vs_first, V_ACTIVE + V_FRONT);
    check("vsync_last_line", vs_last, V_ACTIVE + V_FRONT + V_SYNC - 1);
    check("vblank_activity", vblank_bad, 0);

    // Drop en for one cycle mid-line in the active area, then restart.
    for (int i = 0; i < FRAME && !(m_h == 30 && m_v == 3); i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    drain();
    vid_lat = -1;
    repeat (H_TOTAL + 4) step(1'b0, 1'b1);
    drain();
    check("restart_video_latency", vid_lat, H_BLANK);

    // Reset while the guard band is on the outputs, then run a full frame.
    for (int i = 0; i < FRAME && !(m_h == H_BLANK - GRD && m_v < V_ACTIVE); i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    drain();
    check("sel_after_rst_in_guard", {30'd0, bus.sel}, {30'd0, SEL_BLANK});
    sel11 = 0;
    repeat (FRAME + 4) step(1'b0, 1'b1);
    drain();
    check("sel_never_11", sel11, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/output_timing_ctrl.md
# output_timing_ctrl

Raster timing sequencer that drives the select input of the output mux (blanking / guard / video) for the TMDS output path. It keeps horizontal and vertical position counters and decodes them into mux select, sync, control-preamble and pixel-request signals. It sits between the pixel fetch logic (upstream, driven by `pix_req`) and the output mux / encoders (downstream, driven by `sel`, `ctl`, `hsync`, `vsync`).

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (cycles)
- `H_SYNC`, 96, hsync width
- `H_BACK`, 48, horizontal back porch; must be ≥ `PREAMBLE_LEN`+`GUARD_LEN`
- `V_ACTIVE`, 480, active lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `PREAMBLE_LEN`, 8, control-preamble length before the guard band
- `GUARD_LEN`, 2, video guard band length
- `clk` in 1: pixel clock
- `rst` in 1: synchronous, active-high reset
- `en` in 1: run enable; low holds the sequencer at the frame origin
- `sel` out 2: mux select. 00 is blank, 01 is guard, 10 is video; 11 is never driven.
- `ctl` out 4: control bits for the blanking encoder
- `hsync` out 1: active-high horizontal sync
- `vsync` out 1: active-high vertical sync
- `pix_req` out 1: request the next pixel from upstream, one cycle ahead of video
- `line_start` out 1: one-cycle pulse at h=0
- `frame_start` out 1: one-cycle pulse at (h,v)=(0,0)

## Operation
- Derived values:
  - H_BLANK = H_FRONT+H_SYNC+H_BACK
  - H_TOTAL = H_BLANK+H_ACTIVE
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK
- Counter `h` runs 0..H_TOTAL-1, then wraps to 0 and increments `v`. `v` runs 0..V_TOTAL-1, then wraps to 0.
- Line layout (blanking first): front porch h∈[0,H_FRONT), sync h∈[H_FRONT,H_FRONT+H_SYNC), back porch, video h∈[H_BLANK,H_TOTAL).
- An active line has v<V_ACTIVE. On an active line:
  - preamble h∈[H_BLANK-GUARD_LEN-PREAMBLE_LEN, H_BLANK-GUARD_LEN): sel=00, ctl=4'b0001
  - guard h∈[H_BLANK-GUARD_LEN, H_BLANK): sel=01
  - video: sel=10
- On inactive lines, sel=00 for the whole line. Outside the preamble, ctl=0000.
- hsync is high for h∈[H_FRONT,H_FRONT+H_SYNC) on every line.
- vsync is high for v∈[V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC), for the whole line.
- pix_req is high for h∈[H_BLANK-1, H_TOTAL-2] on active lines: exactly H_ACTIVE cycles per line, each one cycle before the matching video cycle.
- Idle output state: sel=00, ctl=0, hsync=vsync=pix_req=line_start=frame_start=0.
- `rst` or `en`=0 at an edge: counters go to (0,0) and all outputs go to the idle state. This applies mid-frame; no partial-line completion.
- `rst` has priority over `en`.

## Timing
- All outputs are registered.
- If `en` is sampled high at edge k with the block idle, the outputs after edge k+1 show position (0,0): frame_start=1, line_start=1.
- After that, the position advances by one per cycle.
- Output latency from a counter position to its decoded outputs is fixed at 1 cycle. Upstream therefore sees `pix_req` exactly one cycle before `sel`=10 for the same pixel.
- The wrap from h=H_TOTAL-1 to 0 and the v increment happen on the same edge. At (H_TOTAL-1, V_TOTAL-1), the next position is (0,0) with frame_start.
- `en` deasserted for one cycle: the frame restarts from (0,0) when `en` returns.

## Structure
- Shared package `tmds_out_pkg` holds:
  - SEL_BLANK=2'b00, SEL_GUARD=2'b01, SEL_VIDEO=2'b10
  - CTL_IDLE=4'b0000, CTL_VIDEO_PREAMBLE=4'b0001
- Both the output mux and this block import these constants.
- Sub-module `wrap_counter` has parameter MAX, inputs `clk`/`rst`/`clr`/`inc`, and outputs `count` and `wrap`. It is instantiated twice: `h` (inc=1) and `v` (inc=h wrap). Widths are $clog2(MAX+1).
- Decode logic and output registers stay in `output_timing_ctrl`.

## Test plan
- Reset, then `en`=1 with defaults → one cycle later frame_start=1, line_start=1, sel=00. After exactly 800 cycles line_start pulses again; after 420000 cycles frame_start pulses again.
- Line 0 decode → sel=00 at h=0..149 with ctl=0001 at h=150..157, sel=01 at h=158..159, sel=10 at h=160..799; hsync high at h=16..111 only.
- pix_req check on line 0 → high at h=159..798 (640 cycles), and each assertion is followed one cycle later by sel=10.
- Vertical blanking → lines 480..524 have sel=00 throughout, no ctl preamble and no pix_req; vsync high exactly on lines 490..491.
- Deassert `en` at (h=300, v=100) → next cycle all outputs idle. Reassert `en` → frame_start one cycle later, and sel=10 first reappears 160 cycles after frame_start.
- Assert `rst` while `en`=1 during the guard band → next cycle sel=00 and all outputs idle. After release, the sequence restarts from (0,0); sel is never 11 over a full frame.
